// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a producer (master) and the UART transmitter (slave).
interface uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: byte-wide UART transmitter, 8N1 by default; define UART_TX_PARITY_EN
// to insert an even-parity bit (8E1). Synchronous active-high reset.
module uart_tx #(
    parameter int CLK_HZ = 12000000,
    parameter int BAUD   = 115200
) (
    input  logic     clk,
    input  logic     reset,
    uart_tx_if.slave tx_if,
    output logic     txd,
    output logic     busy
);
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             cnt_last;
    logic             accept;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
`endif

    assign tx_if.tx_ready = (state_q == S_IDLE) && !reset;
    assign accept         = tx_if.tx_valid && tx_if.tx_ready;
    assign cnt_last       = (cnt_q == CNT_LAST);
    assign busy           = (state_q != S_IDLE);
    assign txd            = txd_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            txd_q     <= txd_d;
        end
    end

    // NOTE: payload registers carry no reset; they are always loaded on acceptance before use.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        if (accept) parity_q <= ^tx_if.tx_data;
`endif
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = S_START;
                    shift_d = tx_if.tx_data;
                end
            end
            S_START: begin
                if (cnt_last) begin
                    state_d   = S_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    cnt_d     = '0;
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_TX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = S_PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (cnt_last) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (cnt_last) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Line level is registered from the state being entered, so it changes with the state.
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = parity_q;
`endif
            default:  txd_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a timing model predicts acceptances and
// queues expected frames, a monitor compares the serial line bit by bit.
`timescale 1ns/1ps
module tb_uart_tx;
    localparam int CLK_HZ = 4;
    localparam int BAUD   = 1;
    localparam int CPB    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic txd;
    logic busy;

    uart_tx_if u_if ();

    uart_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .reset (reset),
        .tx_if (u_if),
        .txd   (txd),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line image of one frame: start, data LSB first, optional even parity, stop.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = ((int'(b) >> i) % 2) == 1;
            ones  += (int'(b) >> i) % 2;
        end
`ifdef UART_TX_PARITY_EN
        f[9]  = (ones % 2) == 1;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    // Reference timing model: free again FRAME_CYC+1 cycles after an acceptance.
    int          cycle     = 0;
    int          next_free = 0;
    int          acc_cnt   = 0;
    int          acc_time[$];
    logic [10:0] exp_q[$];

    always @(posedge clk) begin
        cycle++;
        if (reset) begin
            next_free = cycle + 1;
        end else if (u_if.tx_valid === 1'b1 && cycle >= next_free) begin
            exp_q.push_back(frame_of(u_if.tx_data));
            acc_cnt++;
            acc_time.push_back(cycle);
            next_free = cycle + FRAME_CYC + 1;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    bit          mon_active  = 1'b0;
    bit          expect_idle = 1'b0;
    bit          prev_rst    = 1'b0;
    int          mon_cyc     = 0;
    int          mon_frames  = 0;
    logic [10:0] cur;

    always @(negedge clk) begin
        check("ready", u_if.tx_ready, !reset && (cycle + 1 >= next_free));
        if (prev_rst) begin
            check("rst_txd", txd, 1);
            check("rst_busy", busy, 0);
            mon_active  = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (!mon_active) begin
                if (expect_idle) begin
                    check("busy_len", busy, 0);
                    expect_idle = 1'b0;
                end else if (busy === 1'b1) begin
                    mon_frames++;
                    check("frame_queued", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur        = exp_q.pop_front();
                        mon_active = 1'b1;
                        mon_cyc    = 0;
                    end
                end else begin
                    check("idle_txd", txd, 1);
                end
            end
            if (mon_active) begin
                check("busy_hold", busy, 1);
                check("txd_bit", txd, cur[mon_cyc / CPB]);
                mon_cyc++;
                if (mon_cyc == FRAME_CYC) begin
                    mon_active  = 1'b0;
                    expect_idle = 1'b1;
                end
            end
        end
        prev_rst = reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit hold);
        int start;
        int n;
        start         = acc_cnt;
        n             = 0;
        u_if.tx_data  = b;
        u_if.tx_valid = 1'b1;
        while (acc_cnt == start && n < 200) begin
            tick();
            n++;
        end
        check("send_accept", acc_cnt - start, 1);
        if (!hold) u_if.tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mon_active || expect_idle || exp_q.size() != 0 || busy !== 1'b0) && n < 400) begin
            tick();
            n++;
        end
        check("idle_timeout", n < 400, 1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int a;
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = 8'hAA;
        reset         = 1'b1;

        // Reset held three cycles with a pending byte: nothing may start.
        repeat (3) tick();
        reset         = 1'b0;
        u_if.tx_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", u_if.tx_ready, 1);
        check("txd_after_rst", txd, 1);
        tick();
        repeat (5) tick();
        check("no_frame_busy", busy, 0);
        check("no_frame_frames", mon_frames, 0);

        // Single byte 0x55.
        send(8'h55, 1'b0);
        wait_idle();

        // Back-to-back with tx_valid held high.
        send(8'hA5, 1'b1);
        t0 = acc_time[$];
        send(8'h3C, 1'b1);
        u_if.tx_valid = 1'b0;
        check("b2b_spacing", acc_time[$] - t0, FRAME_CYC + 1);
        wait_idle();

        // Mid-frame 0xFF pulse while 0x00 is in flight.
        send(8'h00, 1'b0);
        a = mon_frames;
        repeat (8) tick();
        u_if.tx_data  = 8'hFF;
        u_if.tx_valid = 1'b1;
        repeat (12) begin
            check("ready_low_midframe", u_if.tx_ready, 0);
            tick();
        end
        u_if.tx_valid = 1'b0;
        wait_idle();
        check("no_extra_frame", mon_frames, a + 1);

        // Reset during frame 0x55, then a clean 0x0F.
        send(8'h55, 1'b0);
        repeat (12) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_txd", txd, 1);
        check("abort_busy", busy, 0);
        repeat (2) tick();
        send(8'h0F, 1'b0);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b0);
        wait_idle();
        send(8'h03, 1'b0);
        wait_idle();
`endif

        // Randomised traffic with data noise and occasional aborts.
        for (int i = 0; i < 30; i++) begin
            bit hold;
            repeat ($urandom_range(0, 3)) begin
                u_if.tx_data = 8'($urandom);
                tick();
            end
            hold = 1'($urandom_range(0, 1));
            send(8'($urandom), hold);
            if (!hold) begin
                repeat ($urandom_range(0, 6)) begin
                    u_if.tx_data = 8'($urandom);
                    tick();
                end
                if ($urandom_range(0, 7) == 0) begin
                    repeat ($urandom_range(1, 30)) tick();
                    reset = 1'b1;
                    tick();
                    reset = 1'b0;
                end
            end
        end
        u_if.tx_valid = 1'b0;
        wait_idle();
        check("frame_count", mon_frames, acc_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
